// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider result BCD converter.
//   state_t    : converter FSM state encoding
//   DIV_WIDTH  : default binary width of quotient / remainder
//   DIV_DIGITS : default number of BCD digits per result (enough for 2^32-1)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_DIGITS = 10;

    // IDLE waits for a divider strobe, CONV_Q / CONV_R run double-dabble on the
    // quotient and remainder, DONE emits the valid pulse, ERR mirrors the
    // divider error flag until it drops.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_Q = 3'd1,
        CONV_R = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

endpackage : div_pkg

// File: rtl/bcd_add3_shift.sv
// -----------------------------------------------------------------------------
// bcd_add3_shift
// One combinational double-dabble step: every BCD digit of the accumulator that
// is 5 or more gets +3, then {accumulator, shift register} moves left by one.
// Ports:
//   acc_i   : packed BCD accumulator, digit 0 in bits [3:0]
//   shift_i : binary bits still to be shifted in, MSB first
//   acc_o   : accumulator after adjust and shift
//   shift_o : shift register after shift (LSB filled with 0)
// -----------------------------------------------------------------------------
module bcd_add3_shift
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = DIV_DIGITS
) (
    input  logic [4*DIGITS-1:0] acc_i,
    input  logic [WIDTH-1:0]    shift_i,
    output logic [4*DIGITS-1:0] acc_o,
    output logic [WIDTH-1:0]    shift_o
);

    logic [4*DIGITS-1:0]       adjusted;
    logic [4*DIGITS+WIDTH-1:0] joined;

    // Pre-correct each digit so that the following doubling carries cleanly
    // into the next digit; a digit of 5..9 doubled would otherwise land in the
    // illegal 10..18 range. The whole {acc, shift} pair is then shifted as one
    // vector so the MSB of the binary operand feeds digit 0.
    always_comb begin
        adjusted = acc_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_i[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
            end
        end
        joined  = {adjusted, shift_i} << 1;
        acc_o   = joined[4*DIGITS+WIDTH-1:WIDTH];
        shift_o = joined[WIDTH-1:0];
    end

endmodule : bcd_add3_shift

// File: rtl/div_result_bcd.sv
// -----------------------------------------------------------------------------
// div_result_bcd
// Converts the quotient and remainder of an upstream divider into packed BCD,
// one bit per clock, quotient first and then remainder.
// Ports:
//   clk     : clock, all state on the rising edge
//   reset   : asynchronous active-high reset
//   ok      : divider completion level; a rising edge in IDLE starts a conversion
//   err     : divider error level; a rising edge in IDLE enters the error state
//   D, R    : quotient and remainder from the divider
//   q_bcd   : quotient in packed BCD (digit 0 in bits [3:0])
//   r_bcd   : remainder in packed BCD
//   valid   : one-cycle pulse when q_bcd / r_bcd carry a new result
//   busy    : high while a conversion is in progress
//   div_err : high while the error condition is latched
// -----------------------------------------------------------------------------
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = DIV_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ok,
    input  logic                err,
    input  logic [WIDTH-1:0]    D,
    input  logic [WIDTH-1:0]    R,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic                valid,
    output logic                busy,
    output logic                div_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [WIDTH-1:0]    remCap_q, remCap_d;
    logic [4*DIGITS-1:0] qBcd_q, qBcd_d;
    logic [4*DIGITS-1:0] rBcd_q, rBcd_d;
    logic                valid_q;
    logic                ok_q;
    logic                err_q;

    logic                okRise;
    logic                errRise;
    logic [4*DIGITS-1:0] stepAcc;
    logic [WIDTH-1:0]    stepShift;

    // The edge registers reset to 0, so an ok that is already high when reset
    // is released still reads as a fresh rising edge.
    assign okRise  = ok  & ~ok_q;
    assign errRise = err & ~err_q;

    bcd_add3_shift #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .acc_i   (acc_q),
        .shift_i (shift_q),
        .acc_o   (stepAcc),
        .shift_o (stepShift)
    );

    // State and datapath registers. The edge registers track ok/err in every
    // state, which is what makes a level held through a conversion (or toggled
    // during one) unable to retrigger once the FSM is back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            shift_q  <= '0;
            remCap_q <= '0;
            qBcd_q   <= '0;
            rBcd_q   <= '0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shift_q  <= shift_d;
            remCap_q <= remCap_d;
            qBcd_q   <= qBcd_d;
            rBcd_q   <= rBcd_d;
            valid_q  <= (state_q == DONE);
            ok_q     <= ok;
            err_q    <= err;
        end
    end

    // Next-state logic. Each CONV_* state runs WIDTH steps with the counter
    // going WIDTH-1 down to 0; the step taken on count 0 is the last one, so its
    // result goes straight into the output register on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shift_d  = shift_q;
        remCap_d = remCap_q;
        qBcd_d   = qBcd_q;
        rBcd_d   = rBcd_q;

        case (state_q)
            IDLE: begin
                if (errRise) begin
                    state_d = ERR;
                    qBcd_d  = '0;
                    rBcd_d  = '0;
                end else if (okRise) begin
                    shift_d  = D;
                    remCap_d = R;
                    acc_d    = '0;
                    cnt_d    = CNT_START;
                    state_d  = CONV_Q;
                end
            end

            CONV_Q: begin
                acc_d   = stepAcc;
                shift_d = stepShift;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    qBcd_d  = stepAcc;
                    acc_d   = '0;
                    shift_d = remCap_q;
                    cnt_d   = CNT_START;
                    state_d = CONV_R;
                end
            end

            CONV_R: begin
                acc_d   = stepAcc;
                shift_d = stepShift;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    rBcd_d  = stepAcc;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                if (!err) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q_bcd   = qBcd_q;
    assign r_bcd   = rBcd_q;
    assign valid   = valid_q;
    assign busy    = (state_q == CONV_Q) || (state_q == CONV_R) || (state_q == DONE);
    assign div_err = (state_q == ERR);

endmodule : div_result_bcd
